power_pack_ctrl: RTL
====================

# power_pack_ctrl

Frame-based controller that drives the `spawn` and `eaten` inputs of the power-pack renderer. It also owns the power-up lifecycle: cooldown, spawn, pickup detection against the puck, and effect duration. It sits directly upstream of the power-pack renderer and reads back its `rx`/`ry` position. It drives the `effect` flag to the game logic.

## Interface
Parameters:
- `COOLDOWN_FRAMES`, default 180: frames the pack stays hidden before each spawn.
- `LIFETIME_FRAMES`, default 600: frames an uncollected pack stays visible before it is withdrawn.
- `EFFECT_FRAMES`, default 300: frames `effect` stays high after a pickup.
- `PUCK_SIZE`, default 16: puck square side, in pixels.
- `PACK_W`, default 20: pack width; must match the renderer's `WIDTH`.
- `PACK_H`, default 20: pack height; must match the renderer's `HEIGHT`.

Ports:
- `clk`, in, 1: pixel clock; the only clock in the block.
- `reset`, in, 1: asynchronous, active-low reset.
- `vsync`, in, 1: VGA vertical sync, active-low pulse once per frame.
- `puck_x`, in, 11: puck left edge.
- `puck_y`, in, 10: puck top edge.
- `pack_x`, in, 11: pack left edge, taken from the renderer's `rx`.
- `pack_y`, in, 10: pack top edge, taken from the renderer's `ry`.
- `spawn`, out, 1: single-cycle spawn pulse to the renderer.
- `eaten`, out, 1: level; high while the pack must be hidden.
- `effect`, out, 1: level; power-up effect is active.
- `pickups`, out, 4: saturating count of pickups since reset.
- `state`, out, 2: current FSM state, for debug.

## Operation
- Frame tick: `vsync` is registered twice, and a falling edge produces `tick`, a one-cycle strobe.
- All frame counting and collision sampling happen only on `tick`.
- FSM states, encoded on `state`:
  - IDLE (0): cooldown. Frame counter counts ticks. At count == COOLDOWN_FRAMES-1 on a tick, clear the counter and go to SPAWN.
  - SPAWN (1): lasts exactly one cycle. `spawn`=1 and `eaten`=0 in the same cycle, so the renderer's `spawn && !eaten` condition holds. Any tick arriving in this cycle is dropped. Then go to ARMED.
  - ARMED (2): on each tick, evaluate overlap.
    - On a hit: increment `pickups` (saturates at 15), clear the counter, go to EFFECT.
    - Otherwise, when count == LIFETIME_FRAMES-1: clear the counter, go to IDLE; no pickup is counted.
    - Otherwise: increment the counter.
  - EFFECT (3): `effect`=1. At count == EFFECT_FRAMES-1 on a tick, clear the counter and go to IDLE.
- Output decode; all outputs are registered from next-state:
  - `eaten`=1 in IDLE and EFFECT, 0 in SPAWN and ARMED.
  - `spawn`=1 only in SPAWN.
  - `effect`=1 only in EFFECT.
- Overlap test: all four inequalities below must hold. Operands are zero-extended to 12 bits so the sums never wrap.
  - `puck_x < pack_x+PACK_W`
  - `puck_x+PUCK_SIZE > pack_x`
  - `puck_y < pack_y+PACK_H`
  - `puck_y+PUCK_SIZE > pack_y`
- Simultaneous events: if a hit and lifetime expiry occur on the same tick, the hit wins.
- Frame counter: 10 bits wide; every `*_FRAMES` parameter must be between 1 and 1023.

## Timing
- Reset values: state IDLE, counter 0, `spawn`=0, `eaten`=1, `effect`=0, `pickups`=0, vsync synchroniser flops = 1.
- Reset asserted mid-operation returns the block to IDLE immediately, in any state, and any pending `spawn` is cancelled.
- Latency:
  - The `vsync` falling edge at the input produces `tick` 2 cycles later.
  - The state and output change takes effect 1 cycle after `tick`.
- `spawn` is high for exactly 1 cycle per spawn. `eaten` falls in that same cycle and rises again on the EFFECT or IDLE entry.
- `pack_x`/`pack_y` are sampled only in ARMED; their value in any other state is ignored.

## Structure
- Package `power_pack_pkg` holds:
  - the 2-bit state enum: IDLE, SPAWN, ARMED, EFFECT;
  - default frame-count constants;
  - the screen coordinate widths (11 for x, 10 for y).
- Sub-module `frame_tick` holds the `vsync` synchroniser and falling-edge detector, and outputs `tick`. The FSM, counter and overlap comparator stay in the top module.

## Test plan
All scenarios use COOLDOWN_FRAMES=3, LIFETIME_FRAMES=5, EFFECT_FRAMES=4, with `vsync` pulsed every 100 cycles.
- Reset release, puck held far away at (0,0) and pack at (700,500):
  - Expected: `eaten`=1 for 3 ticks, then one `spawn` cycle with `eaten`=0, then ARMED.
  - After 5 ticks in ARMED: back to IDLE with `pickups`=0.
- In ARMED, puck at (690,495) overlapping pack (700,500):
  - On the next tick: EFFECT, `eaten`=1, `effect`=1, `pickups`=1.
  - `effect` falls after 4 ticks.
- Edge adjacency, pack at (700,500):
  - Puck at (684,500), touching the pack's left edge: no hit.
  - Puck at (685,500): hit.
- Hit on the 5th ARMED tick, where lifetime would also expire: EFFECT is entered and `pickups` increments.
- Reset pulled low during EFFECT, held 1 cycle:
  - Immediately: `effect`=0, `eaten`=1, state=0.
  - The full cooldown then restarts.
- 17 consecutive pickups: `pickups` saturates at 15.

Source files
------------

// File: rtl/power_pack_pkg.sv
// power_pack_pkg: shared state encoding, default frame counts and screen coordinate widths
package power_pack_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, SPAWN = 2'd1, ARMED = 2'd2, EFFECT = 2'd3} state_t;
  localparam int COOLDOWN_DEF = 180;
  localparam int LIFETIME_DEF = 600;
  localparam int EFFECT_DEF   = 300;
  localparam int X_W          = 11;
  localparam int Y_W          = 10;
  localparam int CNT_W        = 10;
endpackage

// File: rtl/frame_tick.sv
// frame_tick: vsync synchroniser and falling-edge detector producing a one-cycle frame strobe
//   clk   - pixel clock
//   reset - asynchronous active-low reset
//   vsync - active-low vertical sync from the VGA timing generator
//   tick  - registered one-cycle strobe, two cycles after the vsync falling edge
module frame_tick (
  input  logic clk,
  input  logic reset,
  input  logic vsync,
  output logic tick
);
  logic v1, v2;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      v1   <= 1'b1;
      v2   <= 1'b1;
      tick <= 1'b0;
    end else begin
      v1   <= vsync;
      v2   <= v1;
      tick <= v2 & ~v1;
    end
endmodule

// File: rtl/power_pack_ctrl.sv
// power_pack_ctrl: power-up lifecycle FSM (cooldown, spawn, pickup detection, effect duration)
//   clk, reset       - pixel clock, asynchronous active-low reset
//   vsync            - active-low frame sync
//   puck_x, puck_y   - puck top-left corner
//   pack_x, pack_y   - pack top-left corner read back from the renderer
//   spawn            - one-cycle spawn pulse to the renderer
//   eaten            - high while the pack must be hidden
//   effect           - power-up effect active
//   pickups          - saturating pickup count
//   state            - current FSM state for debug
module power_pack_ctrl import power_pack_pkg::*; #(
  parameter int COOLDOWN_FRAMES = COOLDOWN_DEF,
  parameter int LIFETIME_FRAMES = LIFETIME_DEF,
  parameter int EFFECT_FRAMES   = EFFECT_DEF,
  parameter int PUCK_SIZE       = 16,
  parameter int PACK_W          = 20,
  parameter int PACK_H          = 20
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           vsync,
  input  logic [X_W-1:0] puck_x,
  input  logic [Y_W-1:0] puck_y,
  input  logic [X_W-1:0] pack_x,
  input  logic [Y_W-1:0] pack_y,
  output logic           spawn,
  output logic           eaten,
  output logic           effect,
  output logic [3:0]     pickups,
  output logic [1:0]     state
);
  state_t st, st_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [3:0] pickups_n;
  logic tick, hit;
  frame_tick u_tick (.clk(clk), .reset(reset), .vsync(vsync), .tick(tick));
  // 12-bit zero-extended operands keep the edge sums from wrapping at the screen border
  logic [11:0] px, py, kx, ky;
  assign px  = {1'b0, puck_x};
  assign py  = {2'b0, puck_y};
  assign kx  = {1'b0, pack_x};
  assign ky  = {2'b0, pack_y};
  assign hit = (px < kx + 12'(PACK_W)) && (px + 12'(PUCK_SIZE) > kx) &&
               (py < ky + 12'(PACK_H)) && (py + 12'(PUCK_SIZE) > ky);
  always_comb begin
    st_n      = st;
    cnt_n     = cnt;
    pickups_n = pickups;
    case (st)
      IDLE:
        if (tick) begin
          st_n  = (cnt == CNT_W'(COOLDOWN_FRAMES - 1)) ? SPAWN : IDLE;
          cnt_n = (cnt == CNT_W'(COOLDOWN_FRAMES - 1)) ? '0 : cnt + 1'b1;
        end
      SPAWN: st_n = ARMED;
      ARMED:
        if (tick) begin
          if (hit) begin
            st_n      = EFFECT;
            cnt_n     = '0;
            pickups_n = (pickups == 4'hf) ? pickups : pickups + 4'd1;
          end else begin
            st_n  = (cnt == CNT_W'(LIFETIME_FRAMES - 1)) ? IDLE : ARMED;
            cnt_n = (cnt == CNT_W'(LIFETIME_FRAMES - 1)) ? '0 : cnt + 1'b1;
          end
        end
      EFFECT:
        if (tick) begin
          st_n  = (cnt == CNT_W'(EFFECT_FRAMES - 1)) ? IDLE : EFFECT;
          cnt_n = (cnt == CNT_W'(EFFECT_FRAMES - 1)) ? '0 : cnt + 1'b1;
        end
    endcase
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      st      <= IDLE;
      cnt     <= '0;
      pickups <= '0;
      spawn   <= 1'b0;
      eaten   <= 1'b1;
      effect  <= 1'b0;
    end else begin
      st      <= st_n;
      cnt     <= cnt_n;
      pickups <= pickups_n;
      spawn   <= st_n == SPAWN;
      eaten   <= st_n == IDLE || st_n == EFFECT;
      effect  <= st_n == EFFECT;
    end
  assign state = st;
endmodule
